// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: command encoding, default bus widths and
// the arbiter state encoding used by every slave port arbiter.
package xbar_pkg;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/slave_port_arbiter_rr_pick.sv
// Combinational round-robin selector: returns the first requester found
// when scanning upward from the master after last_grant, wrapping around.
module rr_pick
    import xbar_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       last_grant,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   any_req
);

    // Scan last_grant+1 .. last_grant+NUM_MASTERS; the first hit wins.
    always_comb begin
        int  idx;
        logic found;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx = (int'(last_grant) + k) % NUM_MASTERS;
            if (!found && req[idx]) begin
                grant_idx = IDX_W'(idx);
                found     = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/slave_port_arbiter.sv
// Per-slave round-robin arbitration stage of the crossbar. One master at a
// time is connected to the slave interface; the grant is held until the
// slave acks, the master drops its request, or (with ARB_TIMEOUT_EN
// defined) a watchdog expires and flags m_err to the granted master.
module slave_port_arbiter
    import xbar_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        m_req,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    input  logic [NUM_MASTERS-1:0]        m_cmd,
    output logic [NUM_MASTERS-1:0]        m_ack,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [NUM_MASTERS-1:0]        m_err,
    output logic                          req_to_slave_if,
    output logic [ADDR_W-1:0]             addr_to_slave_if,
    output logic [DATA_W-1:0]             wdata_to_slave_if,
    output logic                          cmd_to_slave_if,
    output logic                          connect_approved,
    input  logic                          ack_from_slave_if,
    input  logic [DATA_W-1:0]             rdata_from_slave_if
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    // Elaboration-time sanity check on the configuration.
    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("slave_port_arbiter: unsupported NUM_MASTERS/TIMEOUT_CYCLES");
    end

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic [IDX_W-1:0] pick_idx;
    logic             any_req;
    logic             timeout_hit;

    logic [ADDR_W-1:0] addr_arr  [NUM_MASTERS];
    logic [DATA_W-1:0] wdata_arr [NUM_MASTERS];

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
        assign addr_arr[i]  = m_addr[i*ADDR_W +: ADDR_W];
        assign wdata_arr[i] = m_wdata[i*DATA_W +: DATA_W];
    end

    rr_pick #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_rr_pick (
        .req        (m_req),
        .last_grant (last_grant_q),
        .grant_idx  (pick_idx),
        .any_req    (any_req)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] to_cnt_q;

    // Watchdog: cleared while idle (so it starts at 0 on entry to BUSY),
    // counts every BUSY cycle; the grant is released before it can wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else if (state_q == ARB_BUSY) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end else begin
            to_cnt_q <= '0;
        end
    end

    // The TIMEOUT_CYCLES-th unacknowledged BUSY cycle is the expiry cycle.
    assign timeout_hit = (state_q == ARB_BUSY) &&
                         (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            grant_idx_q  <= '0;
            last_grant_q <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            state_q      <= state_d;
            grant_idx_q  <= grant_idx_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next-state logic plus the slave-side mux and master-side return path.
    always_comb begin
        state_d           = state_q;
        grant_idx_d       = grant_idx_q;
        last_grant_d      = last_grant_q;
        connect_approved  = 1'b0;
        req_to_slave_if   = 1'b0;
        addr_to_slave_if  = '0;
        wdata_to_slave_if = '0;
        cmd_to_slave_if   = 1'b0;
        m_ack             = '0;
        m_rdata           = '0;
        m_err             = '0;

        unique case (state_q)
            ARB_IDLE: begin
                if (any_req) begin
                    grant_idx_d = pick_idx;
                    state_d     = ARB_BUSY;
                end
            end

            ARB_BUSY: begin
                connect_approved  = 1'b1;
                req_to_slave_if   = m_req[grant_idx_q];
                addr_to_slave_if  = addr_arr[grant_idx_q];
                wdata_to_slave_if = wdata_arr[grant_idx_q];
                cmd_to_slave_if   = m_cmd[grant_idx_q];

                if (!m_req[grant_idx_q]) begin
                    // Master withdrew: release without acking.
                    state_d      = ARB_IDLE;
                    last_grant_d = grant_idx_q;
                end else if (ack_from_slave_if) begin
                    m_ack[grant_idx_q] = 1'b1;
                    if (m_cmd[grant_idx_q] == CMD_READ) begin
                        m_rdata = rdata_from_slave_if;
                    end
                    state_d      = ARB_IDLE;
                    last_grant_d = grant_idx_q;
                end else if (timeout_hit) begin
                    m_err[grant_idx_q] = 1'b1;
                    state_d            = ARB_IDLE;
                    last_grant_d       = grant_idx_q;
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

endmodule
